serv_ctrl_wide: RTL



---
 rtl/serv_ctrl_wide.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/serv_ctrl_wide.sv
// -----------------------------------------------------------------------------
// serv_ctrl_wide
//
// Program-counter control for the serial core, processing the PC W bits per
// cycle. A pass lasts N = 32/W cycles. During a pass the PC register is
// rotated right by W bits per cycle. The chunk shifted in at the top is the
// matching chunk of the next PC, so after N cycles the register holds the
// new PC.
//
// The next PC is taken from one of three sources:
//   - PC + 4, or PC + 2 for compressed instructions when WITH_C is set;
//   - the offset adder result (jump/branch);
//   - the CSR trap/return target, when WITH_CSR is set.
//
// The offset adder also produces rd for LUI/AUIPC, and the increment adder
// produces the link value for JAL/JALR. An internal chunk counter tracks the
// position inside the pass, so no external count strobes are needed.
//
// Parameters
//   W              chunk width per cycle (1, 2 or 4)
//   RESET_STRATEGY "NONE" leaves the PC out of reset (initial value only)
//   RESET_PC       PC value after reset
//   WITH_CSR       enables the trap/mret target path
//   WITH_C         enables +2 increments and 2-byte jump alignment
//
// Ports
//   clk         clock
//   i_rst       synchronous reset, active high, wins over i_pc_en
//   i_pc_en     pass active, one chunk per cycle
//   i_jump      take the offset adder result as the new PC
//   i_rd_en     drive o_rd
//   i_utype     offset is the U-immediate instead of i_buf
//   i_pc_rel    add the current PC into the offset adder
//   i_iscomp    compressed instruction (increment of 2, WITH_C only)
//   i_trap      take i_csr_pc as the new PC
//   i_imm       immediate chunk
//   i_buf       rs1-based offset chunk
//   i_csr_pc    trap/return target chunk
//   o_rd        rd writeback chunk (combinational)
//   o_bad_pc    unaligned jump target chunk (combinational, for mtval)
//   o_misalign  jump target misaligned, valid after the pass ends
//   o_ibus_adr  current PC
// -----------------------------------------------------------------------------
module serv_ctrl_wide #(
  parameter int          W              = 1,
  parameter string       RESET_STRATEGY = "MINI",
  parameter logic [31:0] RESET_PC       = 32'd0,
  parameter bit          WITH_CSR       = 1'b1,
  parameter bit          WITH_C         = 1'b0
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_pc_en,
  input  logic          i_jump,
  input  logic          i_rd_en,
  input  logic          i_utype,
  input  logic          i_pc_rel,
  input  logic          i_iscomp,
  input  logic          i_trap,
  input  logic [W-1:0]  i_imm,
  input  logic [W-1:0]  i_buf,
  input  logic [W-1:0]  i_csr_pc,
  output logic [W-1:0]  o_rd,
  output logic [W-1:0]  o_bad_pc,
  output logic          o_misalign,
  output logic [31:0]   o_ibus_adr
);

  localparam int N      = 32 / W;
  localparam int CW     = $clog2(N);
  localparam bit RST_PC = (RESET_STRATEGY != "NONE");
  localparam bit SERIAL = (W == 1);
  // Index of target bit 1 within its chunk. For W=1 that bit is in chunk 1.
  localparam int BIT1_IDX = SERIAL ? 0 : 1;

  // Only power-of-two widths up to 4 keep the pass length and the U-immediate
  // boundary (bit 12) aligned to chunk edges.
  if (!((W == 1) || (W == 2) || (W == 4))) begin : g_bad_width
    $error("serv_ctrl_wide: W must be 1, 2 or 4");
  end

  logic [CW-1:0] cnt_r;
  logic          cy4_r;
  logic          cyo_r;
  logic          misalign_r;
  // The initialiser provides the power-up PC when the PC is not reset.
  logic [31:0]   pc_r = RESET_PC;

  logic          cnt0_s;
  logic [31:0]   bit_idx_s;
  logic [31:0]   inc_full_s;
  logic [W-1:0]  pc_chunk_s;
  logic [W-1:0]  inc_chunk_s;
  logic [W-1:0]  p4_s;
  logic          cy4_s;
  logic [W-1:0]  off_a_s;
  logic [W-1:0]  off_b_s;
  logic [W-1:0]  po_s;
  logic          cyo_s;
  logic [W-1:0]  tgt_s;
  logic [W-1:0]  trap_mask_s;
  logic [W-1:0]  trap_chunk_s;
  logic [W-1:0]  new_chunk_s;
  logic [W-1:0]  rd_s;
  logic          mis_load_s;
  logic          mis_next_s;

  // Chunk position, the two chunk adders and the next-PC chunk selection.
  always_comb begin
    cnt0_s     = (cnt_r == {CW{1'b0}});
    bit_idx_s  = 32'(cnt_r) * 32'(W);
    pc_chunk_s = pc_r[W-1:0];

    // Increment adder: the constant is sliced per chunk. Its carry chains
    // through cy4_r, and any carry out of bit 31 is dropped at pass end.
    inc_full_s  = (WITH_C && i_iscomp) ? 32'd2 : 32'd4;
    inc_chunk_s = W'(inc_full_s >> bit_idx_s);
    {cy4_s, p4_s} = {1'b0, pc_chunk_s} + {1'b0, inc_chunk_s} + {{W{1'b0}}, cy4_r};

    // Offset adder. The U-immediate contributes only from bit 12 upward.
    off_a_s = i_pc_rel ? pc_chunk_s : {W{1'b0}};
    if (i_utype) begin
      off_b_s = (bit_idx_s >= 32'd12) ? i_imm : {W{1'b0}};
    end else begin
      off_b_s = i_buf;
    end
    {cyo_s, po_s} = {1'b0, off_a_s} + {1'b0, off_b_s} + {{W{1'b0}}, cyo_r};

    // Jump targets always have bit 0 cleared. Bit 0 lives in chunk 0.
    tgt_s = po_s & ~(W'(cnt0_s));

    // Trap targets have PC bits [1:0] cleared. For W=1 these bits span the
    // first two chunks, so the mask is built from absolute bit positions.
    trap_mask_s = {W{1'b0}};
    for (int k = 0; k < W; k++) begin
      trap_mask_s[k] = ((bit_idx_s + 32'(k)) < 32'd2);
    end
    trap_chunk_s = i_csr_pc & ~trap_mask_s;

    if (WITH_CSR && i_trap) begin
      new_chunk_s = trap_chunk_s;
    end else if (i_jump) begin
      new_chunk_s = tgt_s;
    end else begin
      new_chunk_s = p4_s;
    end

    if (i_rd_en) begin
      rd_s = i_utype ? tgt_s : p4_s;
    end else begin
      rd_s = {W{1'b0}};
    end

    // Misalignment is judged on target bit 1. For W>=2 that bit is in
    // chunk 0. For W=1 the flag is cleared in chunk 0 and loaded in chunk 1.
    mis_load_s = i_pc_en && (cnt0_s || (SERIAL && (cnt_r == CW'(1'b1))));
    if (SERIAL && cnt0_s) begin
      mis_next_s = 1'b0;
    end else begin
      mis_next_s = i_jump & po_s[BIT1_IDX] & ~WITH_C;
    end
  end

  // Chunk counter, adder carries and misalignment flag.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      cnt_r      <= {CW{1'b0}};
      cy4_r      <= 1'b0;
      cyo_r      <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      // N is a power of two, so the counter wraps from N-1 to 0 on its own.
      if (i_pc_en) begin
        cnt_r <= cnt_r + CW'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
      // Gating with i_pc_en guarantees clean carries at the start of a pass.
      cy4_r <= i_pc_en & cy4_s;
      cyo_r <= i_pc_en & cyo_s;
      if (mis_load_s) begin
        misalign_r <= mis_next_s;
      end else begin
        misalign_r <= misalign_r;
      end
    end
  end

  // PC rotate register. The new chunk enters at the top each pass cycle.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      if (RST_PC) begin
        pc_r <= RESET_PC;
      end else begin
        pc_r <= pc_r;
      end
    end else if (i_pc_en) begin
      pc_r <= {new_chunk_s, pc_r[31:W]};
    end else begin
      pc_r <= pc_r;
    end
  end

  assign o_rd       = rd_s;
  assign o_bad_pc   = po_s;
  assign o_misalign = misalign_r;
  assign o_ibus_adr = pc_r;

endmodule
